// File: rtl/rstseq_pkg.sv
// rtl/rstseq_pkg.sv - shared constants and state encoding for the rstseq07 reset sequencer
package rstseq_pkg;
  localparam int NDOM = 7;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    REL    = 2'd1,
    RUN    = 2'd2,
    SWHOLD = 2'd3
  } state_t;

  localparam logic [NDOM-1:0] ALL_MASK = '1;
endpackage

// File: rtl/rstseq_pend.sv
// rtl/rstseq_pend.sv - pending software-reset accumulator; RSTSEQ_SWLOCK_EN adds swlock filtering
module rstseq_pend
  import rstseq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_,
  input  logic [NDOM-1:0] swrst_req,
`ifdef RSTSEQ_SWLOCK_EN
  input  logic [NDOM-1:0] swlock,
`endif
  input  logic            accept,
  input  logic            flush,
  output logic [NDOM-1:0] req,
  output logic [NDOM-1:0] pend
);

  logic [NDOM-1:0] filt;

`ifdef RSTSEQ_SWLOCK_EN
  assign filt = swrst_req & ~swlock;
`else
  assign filt = swrst_req;
`endif

  // Locked bits never reach pend, so a lock cannot revive or cancel an accepted hold.
  assign req = filt | pend;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pend <= '0;
    end else if (flush || accept) begin
      pend <= '0;
    end else begin
      pend <= req;
    end
  end

endmodule

// File: rtl/rstseq07.sv
// rtl/rstseq07.sv - seven-domain staggered reset sequencer; optional swlock input via RSTSEQ_SWLOCK_EN
module rstseq07
  import rstseq_pkg::*;
#(
  parameter int HOLDCYC = 16,
  parameter int GAPCYC  = 4,
  parameter int SWCYC   = 8
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            scanmode,
  input  logic            glbrst_req,
  input  logic [NDOM-1:0] swrst_req,
`ifdef RSTSEQ_SWLOCK_EN
  input  logic [NDOM-1:0] swlock,
`endif
  output logic [NDOM-1:0] rstmsk,
  output logic            rdy,
  output logic            swdone
);

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLDCYC - 1);
  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAPCYC - 1);
  localparam logic [CNTW-1:0] SW_LAST   = CNTW'(SWCYC - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(NDOM - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [2:0]      idx;
  logic [NDOM-1:0] rstmsk_reg;
  logic [NDOM-1:0] act;
  logic [NDOM-1:0] req;
  logic [NDOM-1:0] pend;
  logic            accept;
  logic            flush;

  assign accept = (state == RUN);
  // A global request in HOLD only restarts the hold; queued software requests survive it.
  assign flush  = glbrst_req && (state != HOLD);

  rstseq_pend u_pend (
    .clk       (clk),
    .rst_      (rst_),
    .swrst_req (swrst_req),
`ifdef RSTSEQ_SWLOCK_EN
    .swlock    (swlock),
`endif
    .accept    (accept),
    .flush     (flush),
    .req       (req),
    .pend      (pend)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      rstmsk_reg <= ALL_MASK;
      act        <= '0;
      rdy        <= 1'b0;
      swdone     <= 1'b0;
    end else begin
      swdone <= 1'b0;
      if (glbrst_req) begin
        state      <= HOLD;
        cnt        <= '0;
        idx        <= '0;
        rstmsk_reg <= ALL_MASK;
        act        <= '0;
        rdy        <= 1'b0;
      end else begin
        case (state)
          HOLD: begin
            rstmsk_reg <= ALL_MASK;
            if (cnt == HOLD_LAST) begin
              cnt   <= '0;
              idx   <= '0;
              state <= REL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REL: begin
            if (cnt == GAP_LAST) begin
              cnt        <= '0;
              rstmsk_reg <= rstmsk_reg & ~(NDOM'(1) << idx);
              if (idx == LAST_IDX) begin
                state <= RUN;
                rdy   <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (|req) begin
              rstmsk_reg <= rstmsk_reg | req;
              act        <= req;
              cnt        <= '0;
              state      <= SWHOLD;
            end
          end
          SWHOLD: begin
            if (cnt == SW_LAST) begin
              rstmsk_reg <= rstmsk_reg & ~act;
              swdone     <= 1'b1;
              cnt        <= '0;
              state      <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

  assign rstmsk = scanmode ? '0 : rstmsk_reg;

endmodule

// File: tb/tb_rstseq07.sv
// tb/tb_rstseq07.sv - directed self-checking bench for rstseq07; RSTSEQ_SWLOCK_EN enables the lock test
module tb_rstseq07;

  logic       clk = 1'b0;
  logic       rst_;
  logic       scanmode;
  logic       glbrst_req;
  logic [6:0] swrst_req;
  logic [6:0] rstmsk;
  logic       rdy;
  logic       swdone;
`ifdef RSTSEQ_SWLOCK_EN
  logic [6:0] swlock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rstseq07 dut (
    .clk        (clk),
    .rst_       (rst_),
    .scanmode   (scanmode),
    .glbrst_req (glbrst_req),
    .swrst_req  (swrst_req),
`ifdef RSTSEQ_SWLOCK_EN
    .swlock     (swlock),
`endif
    .rstmsk     (rstmsk),
    .rdy        (rdy),
    .swdone     (swdone)
  );

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Expected mask e edges into a full sequence with default timing.
  function automatic logic [6:0] seq_mask(input int e);
    logic [6:0] m;
    m = 7'h7F;
    for (int i = 0; i < 7; i++) if (e >= 20 + 4 * i) m[i] = 1'b0;
    return m;
  endfunction

  task automatic test_reset();
    rst_ = 1'b0; scanmode = 1'b0; glbrst_req = 1'b0; swrst_req = 7'h00;
`ifdef RSTSEQ_SWLOCK_EN
    swlock = 7'h00;
`endif
    #12;
    n_cmp++; if (rstmsk !== 7'h7F) begin n_bad++; $display("FAIL reset_msk: got %h want 7f", rstmsk); end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    n_cmp++; if (swdone !== 1'b0) begin n_bad++; $display("FAIL reset_swdone: got %b want 0", swdone); end
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic run_sequence(input string tag);
    for (int e = 1; e <= 44; e++) begin
      step(1);
      n_cmp++;
      if (rstmsk !== seq_mask(e) || rdy !== (e >= 44) || swdone !== 1'b0) begin
        n_bad++;
        $display("FAIL %s edge %0d: got msk=%h rdy=%b swdone=%b want msk=%h rdy=%b swdone=0",
                 tag, e, rstmsk, rdy, swdone, seq_mask(e), (e >= 44));
      end
    end
  endtask

  task automatic test_powerup();
    run_sequence("powerup");
  endtask

  task automatic test_swreset();
    swrst_req = 7'h05;
    step(1);
    swrst_req = 7'h00;
    n_cmp++; if (rstmsk !== 7'h05 || rdy !== 1'b1) begin n_bad++; $display("FAIL sw_start: got msk=%h rdy=%b want 05 1", rstmsk, rdy); end
    for (int j = 1; j <= 7; j++) begin
      step(1);
      n_cmp++;
      if (rstmsk !== 7'h05 || swdone !== 1'b0 || rdy !== 1'b1) begin
        n_bad++; $display("FAIL sw_hold k+%0d: got msk=%h swdone=%b rdy=%b want 05 0 1", j, rstmsk, swdone, rdy);
      end
    end
    step(1);
    n_cmp++; if (rstmsk !== 7'h00 || swdone !== 1'b1 || rdy !== 1'b1) begin n_bad++; $display("FAIL sw_end: got msk=%h swdone=%b rdy=%b want 00 1 1", rstmsk, swdone, rdy); end
    step(1);
    n_cmp++; if (swdone !== 1'b0) begin n_bad++; $display("FAIL sw_pulse_width: got %b want 0", swdone); end
  endtask

  task automatic test_accum();
    int pulses;
    logic [6:0] exp;
    pulses = 0;
    swrst_req = 7'h01;
    step(1);
    swrst_req = 7'h00;
    step(3);
    swrst_req = 7'h08;
    step(1);
    swrst_req = 7'h00;
    n_cmp++; if (rstmsk !== 7'h01) begin n_bad++; $display("FAIL acc_mid: got %h want 01", rstmsk); end
    for (int j = 5; j <= 18; j++) begin
      step(1);
      if (swdone === 1'b1) pulses++;
      exp = (j < 8) ? 7'h01 : (j == 8) ? 7'h00 : (j <= 16) ? 7'h08 : 7'h00;
      n_cmp++; if (rstmsk !== exp) begin n_bad++; $display("FAIL acc k+%0d: got %h want %h", j, rstmsk, exp); end
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL acc_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_glbrst();
    glbrst_req = 1'b1;
    step(1);
    glbrst_req = 1'b0;
    n_cmp++; if (rstmsk !== 7'h7F || rdy !== 1'b0) begin n_bad++; $display("FAIL glb_run: got msk=%h rdy=%b want 7f 0", rstmsk, rdy); end
    for (int r = 1; r <= 29; r++) step(1);
    n_cmp++; if (rstmsk !== 7'h78) begin n_bad++; $display("FAIL glb_idx3: got %h want 78", rstmsk); end
    glbrst_req = 1'b1;
    step(1);
    glbrst_req = 1'b0;
    n_cmp++; if (rstmsk !== 7'h7F || rdy !== 1'b0) begin n_bad++; $display("FAIL glb_rel: got msk=%h rdy=%b want 7f 0", rstmsk, rdy); end
    run_sequence("glb_repeat");
  endtask

  task automatic test_glb_swhold();
    swrst_req = 7'h10;
    step(1);
    swrst_req = 7'h00;
    step(2);
    glbrst_req = 1'b1;
    step(1);
    glbrst_req = 1'b0;
    n_cmp++; if (rstmsk !== 7'h7F || rdy !== 1'b0 || swdone !== 1'b0) begin n_bad++; $display("FAIL glb_swhold: got msk=%h rdy=%b swdone=%b want 7f 0 0", rstmsk, rdy, swdone); end
    run_sequence("glb_swhold_seq");
  endtask

  task automatic test_scan();
    glbrst_req = 1'b1;
    scanmode   = 1'b1;
    step(1);
    glbrst_req = 1'b0;
    n_cmp++; if (rstmsk !== 7'h00 || rdy !== 1'b0) begin n_bad++; $display("FAIL scan_hold: got msk=%h rdy=%b want 00 0", rstmsk, rdy); end
    step(24);
    n_cmp++; if (rstmsk !== 7'h00) begin n_bad++; $display("FAIL scan_r24: got %h want 00", rstmsk); end
    step(1);
    scanmode = 1'b0;
    #1;
    n_cmp++; if (rstmsk !== 7'h7C) begin n_bad++; $display("FAIL scan_exit: got %h want 7c", rstmsk); end
    step(5);
    n_cmp++; if (rstmsk !== 7'h78) begin n_bad++; $display("FAIL scan_r30: got %h want 78", rstmsk); end
    step(14);
    n_cmp++; if (rstmsk !== 7'h00 || rdy !== 1'b1) begin n_bad++; $display("FAIL scan_r44: got msk=%h rdy=%b want 00 1", rstmsk, rdy); end
  endtask

`ifdef RSTSEQ_SWLOCK_EN
  task automatic test_swlock();
    swlock    = 7'h02;
    swrst_req = 7'h03;
    step(1);
    swrst_req = 7'h00;
    for (int j = 0; j <= 7; j++) begin
      if (j > 0) step(1);
      n_cmp++; if (rstmsk !== 7'h01) begin n_bad++; $display("FAIL lock k+%0d: got %h want 01", j, rstmsk); end
    end
    step(1);
    n_cmp++; if (rstmsk !== 7'h00 || swdone !== 1'b1) begin n_bad++; $display("FAIL lock_end: got msk=%h swdone=%b want 00 1", rstmsk, swdone); end
    step(1);
    n_cmp++; if (rstmsk !== 7'h00) begin n_bad++; $display("FAIL lock_after: got %h want 00", rstmsk); end
    swlock = 7'h00;
  endtask
`endif

  task automatic test_async_reset();
    swrst_req = 7'h01;
    step(1);
    swrst_req = 7'h00;
    n_cmp++; if (rstmsk !== 7'h01) begin n_bad++; $display("FAIL arst_pre: got %h want 01", rstmsk); end
    #2 rst_ = 1'b0;
    #1;
    n_cmp++; if (rstmsk !== 7'h7F || rdy !== 1'b0 || swdone !== 1'b0) begin n_bad++; $display("FAIL arst: got msk=%h rdy=%b swdone=%b want 7f 0 0", rstmsk, rdy, swdone); end
    @(negedge clk);
    rst_ = 1'b1;
    run_sequence("arst_seq");
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_swreset();
    test_accum();
    test_glbrst();
    test_glb_swhold();
    test_scan();
`ifdef RSTSEQ_SWLOCK_EN
    test_swlock();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
